pixel_capture: RTL and testbench

//  Responder side of the master controller's go / pixel_done handshake. On a go pulse,

---
 rtl/pixel_capture.sv | 125 ++++++++++++
 tb/tb_pixel_capture.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_capture.sv
// Pixel capture responder: on go, waits the galvo settle time, captures pixel_len ADC
// samples into a single-entry stream output register, then holds pixel_done for the controller.
module pixel_capture #(
  parameter int SAMPLE_W  = 16,
  parameter int CNT_W     = 12,
  parameter int SETTLE_W  = 8,
  parameter int DONE_HOLD = 4
) (
  input  logic                clk_adc,
  input  logic                rst_adc,
  input  logic                go,
  input  logic [CNT_W-1:0]    pixel_len,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                disable_fifowr,
  input  logic                err_clr,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  output logic [SAMPLE_W-1:0] m_data,
  output logic                m_valid,
  output logic                m_last,
  input  logic                m_ready,
  output logic                pixel_done,
  output logic                busy,
  output logic [CNT_W-1:0]    sample_cnt,
  output logic                overflow,
  output logic                go_ignored
);

  localparam int                  HOLD_W    = $clog2(DONE_HOLD + 1);
  localparam logic [HOLD_W-1:0]   HOLD_INIT = HOLD_W'(DONE_HOLD - 1);
  localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [SETTLE_W-1:0] SET_ONE   = SETTLE_W'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    len_q;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                take, last_take, load, drop, all_taken;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] lim);
    return (cnt < lim) ? cnt + CNT_ONE : lim;
  endfunction

  always_comb begin
    take      = (state == CAPTURE) && adc_valid && (sample_cnt < len_q);
    last_take = take && ((sample_cnt + CNT_ONE) == len_q);
    load      = take && !disable_fifowr && (!m_valid || m_ready);
    drop      = take && !disable_fifowr && m_valid && !m_ready;
    all_taken = (sample_cnt == len_q);
  end

  always_ff @(posedge clk_adc) begin
    if (rst_adc) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (go) state_d = (pixel_len == '0) ? DONE : SETTLE;
      SETTLE:  if (settle_cnt == '0) state_d = CAPTURE;
      // The last beat must be empty or leaving before the pixel is declared done
      CAPTURE: if (all_taken && (!m_valid || m_ready)) state_d = DONE;
      DONE:    if (hold_cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk_adc) begin
    if (rst_adc) begin
      len_q      <= '0;
      settle_cnt <= '0;
      hold_cnt   <= '0;
      sample_cnt <= '0;
      pixel_done <= 1'b0;
      overflow   <= 1'b0;
      go_ignored <= 1'b0;
    end else begin
      pixel_done <= (state_d == DONE);
      if (state == IDLE && go) begin
        len_q      <= pixel_len;
        settle_cnt <= settle_cycles;
        sample_cnt <= '0;
      end else if (take) begin
        sample_cnt <= sat_inc(sample_cnt, len_q);
      end
      if (state == SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - SET_ONE;
      if (state != DONE)        hold_cnt <= HOLD_INIT;
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - HOLD_ONE;
      // Sticky flags: a new event in the same cycle as err_clr keeps the flag set
      if (drop)         overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (go && state != IDLE) go_ignored <= 1'b1;
      else if (err_clr)        go_ignored <= 1'b0;
    end
  end

  // Output register stage: adc sample -> m_* one clock later
  always_ff @(posedge clk_adc) begin
    if (rst_adc) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_data  <= adc_data;
      m_valid <= 1'b1;
      m_last  <= last_take;
    end else begin
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      if (drop && last_take) m_last <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_capture.sv
// Bench for pixel_capture: randomized pixels against a cycle-count reference model,
// with a scoreboard queue popped by an independent output monitor.
module tb_pixel_capture;
  localparam int SAMPLE_W  = 16;
  localparam int CNT_W     = 12;
  localparam int SETTLE_W  = 8;
  localparam int DONE_HOLD = 4;

  logic                clk_adc = 1'b0;
  logic                rst_adc, go, disable_fifowr, err_clr, adc_valid, m_ready;
  logic [CNT_W-1:0]    pixel_len;
  logic [SETTLE_W-1:0] settle_cycles;
  logic [SAMPLE_W-1:0] adc_data, m_data;
  logic                m_valid, m_last, pixel_done, busy, overflow, go_ignored;
  logic [CNT_W-1:0]    sample_cnt;

  pixel_capture #(.SAMPLE_W(SAMPLE_W), .CNT_W(CNT_W), .SETTLE_W(SETTLE_W), .DONE_HOLD(DONE_HOLD)) dut (
    .clk_adc(clk_adc), .rst_adc(rst_adc), .go(go), .pixel_len(pixel_len),
    .settle_cycles(settle_cycles), .disable_fifowr(disable_fifowr), .err_clr(err_clr),
    .adc_data(adc_data), .adc_valid(adc_valid), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .pixel_done(pixel_done), .busy(busy),
    .sample_cnt(sample_cnt), .overflow(overflow), .go_ignored(go_ignored)
  );

  always #5 clk_adc = ~clk_adc;

  typedef struct packed {logic [SAMPLE_W-1:0] d; logic l;} beat_t;
  beat_t exp_q[$];

  int n_checks = 0, n_pass = 0;
  bit armed = 0;

  // Reference model state: pixel timing expressed as edge numbers
  int edge_n = 0, cap_from = 0, done_end = 0, m_len = 0, taken = 0, e_cnt = 0, e_done_cnt = 0;
  bit mb = 0, in_done = 0, full = 0, e_ovf = 0, e_gi = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  int done_run = 0, done_pulses = 0;
  always @(negedge clk_adc) begin
    if (armed) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("beat_pending", exp_q.size(), 1);
        else begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_data", m_data, b.d);
          check("beat_last", m_last, b.l);
        end
      end
      if (pixel_done) done_run++;
      else if (done_run > 0) begin
        check("done_len", done_run, DONE_HOLD);
        done_pulses++;
        done_run = 0;
      end
    end
  end

  task automatic model_edge();
    bit set_ovf, set_gi, cap;
    beat_t b;
    set_ovf = 0; set_gi = 0;
    edge_n++;
    if (rst_adc) begin
      mb = 0; in_done = 0; full = 0; exp_q.delete();
      e_ovf = 0; e_gi = 0; e_cnt = 0; taken = 0;
      return;
    end
    if (in_done && edge_n > done_end) begin mb = 0; in_done = 0; end
    if (!mb) begin
      if (go) begin
        mb = 1; m_len = int'(pixel_len); taken = 0; e_cnt = 0;
        cap_from = edge_n + int'(settle_cycles) + 2;
        if (m_len == 0) begin in_done = 1; done_end = edge_n + DONE_HOLD; e_done_cnt++; end
      end
      full = full && !m_ready;
    end else begin
      if (go) set_gi = 1;
      cap = !in_done && edge_n >= cap_from;
      if (cap && taken == m_len && (!full || m_ready)) begin
        in_done = 1; done_end = edge_n + DONE_HOLD; e_done_cnt++; full = 0;
      end else if (cap && taken < m_len && adc_valid) begin
        taken++; e_cnt = taken;
        if (disable_fifowr) full = full && !m_ready;
        else if (!full || m_ready) begin
          b.d = adc_data; b.l = (taken == m_len); exp_q.push_back(b); full = 1;
        end else begin
          set_ovf = 1;
          if (taken == m_len && exp_q.size() > 0) begin
            b = exp_q.pop_back(); b.l = 1'b1; exp_q.push_back(b);
          end
        end
      end else full = full && !m_ready;
    end
    e_ovf = set_ovf | (e_ovf & !err_clr);
    e_gi  = set_gi  | (e_gi  & !err_clr);
  endtask

  task automatic tick();
    @(posedge clk_adc);
    model_edge();
    #1;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
  endtask

  task automatic run_pixel(input int len, input int settle, input int vprob, input int rprob,
                           input bit dis, input bit seq, input int stall, input int go2_cyc,
                           input int rst_taken);
    int cyc, stall_left;
    stall_left = stall;
    pixel_len = CNT_W'(len); settle_cycles = SETTLE_W'(settle);
    disable_fifowr = dis; go = 1'b1; adc_valid = 1'b0; m_ready = 1'b1;
    tick();
    go = 1'b0;
    if (len == 0) check("len0_done_fast", pixel_done, 1);
    cyc = 0;
    while (mb && !(in_done && edge_n >= done_end)) begin
      if (cyc > 3000) begin check("pixel_timeout", cyc, 3000); break; end
      adc_valid = ($urandom_range(99) < vprob);
      adc_data  = seq ? SAMPLE_W'(32'h10 + taken) : SAMPLE_W'($urandom);
      m_ready   = ($urandom_range(99) < rprob);
      if (stall_left > 0 && edge_n + 1 >= cap_from && !in_done) begin
        m_ready = 1'b0; stall_left--;
      end
      pixel_len = CNT_W'($urandom); settle_cycles = SETTLE_W'($urandom);
      go = (cyc == go2_cyc);
      if (rst_taken >= 0 && taken == rst_taken && !in_done) begin
        rst_adc = 1'b1; tick(); rst_adc = 1'b0; go = 1'b0;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_pixel_done", pixel_done, 0);
        check("rst_busy", busy, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        tick(); tick();
        check("rst_no_done", done_pulses, e_done_cnt);
        return;
      end
      tick();
      cyc++;
    end
    go = 1'b0; adc_valid = 1'b0; m_ready = 1'b1;
    tick();
    check("end_busy", busy, 0);
    check("end_sample_cnt", sample_cnt, e_cnt);
    check("end_overflow", overflow, e_ovf);
    check("end_go_ignored", go_ignored, e_gi);
    check("end_done_pulses", done_pulses, e_done_cnt);
    check("end_queue_left", exp_q.size(), 0);
  endtask

  initial begin
    rst_adc = 1'b1; go = 1'b0; pixel_len = '0; settle_cycles = '0; disable_fifowr = 1'b0;
    err_clr = 1'b0; adc_data = '0; adc_valid = 1'b0; m_ready = 1'b1;
    repeat (3) tick();
    rst_adc = 1'b0;
    armed = 1;
    check("reset_m_valid", m_valid, 0);
    check("reset_m_last", m_last, 0);
    check("reset_m_data", m_data, 0);
    check("reset_pixel_done", pixel_done, 0);
    check("reset_busy", busy, 0);
    check("reset_sample_cnt", sample_cnt, 0);
    check("reset_overflow", overflow, 0);
    check("reset_go_ignored", go_ignored, 0);

    run_pixel(4, 3, 100, 100, 0, 1, 0, -1, -1);
    check("t1_sample_cnt", sample_cnt, 4);

    run_pixel(3, 2, 100, 100, 0, 1, 5, -1, -1);
    check("t2_overflow", overflow, 1);
    check("t2_sample_cnt", sample_cnt, 3);
    pulse_err_clr();
    check("t2_overflow_clr", overflow, 0);

    run_pixel(0, 5, 100, 100, 0, 0, 0, -1, -1);
    run_pixel(1, 0, 100, 100, 0, 0, 0, -1, -1);

    run_pixel(6, 1, 100, 100, 0, 0, 0, 4, -1);
    check("t4_go_ignored", go_ignored, 1);
    pulse_err_clr();
    check("t4_go_ignored_clr", go_ignored, 0);

    run_pixel(8, 2, 100, 100, 0, 0, 0, -1, 2);
    run_pixel(8, 1, 100, 100, 0, 0, 0, -1, -1);
    check("t5_sample_cnt", sample_cnt, 8);

    run_pixel(5, 2, 100, 100, 1, 0, 0, -1, -1);
    check("t6_sample_cnt", sample_cnt, 5);

    for (int i = 0; i < 25; i++) begin
      run_pixel($urandom_range(12), $urandom_range(6), $urandom_range(30, 100),
                $urandom_range(30, 100), ($urandom_range(9) == 0), 0, 0,
                ($urandom_range(3) == 0) ? int'($urandom_range(1, 20)) : -1, -1);
      if ($urandom_range(2) == 0) pulse_err_clr();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
